// File: rtl/data_mem_lsu_if.sv
// -----------------------------------------------------------------------------
// data_mem_lsu_if
// Request/response bundle between the core's memory stage and data_mem_lsu.
//   req_valid/req_ready   request handshake
//   req_we                1 = store, 0 = load
//   req_size              log2 of access size in bytes (0..3)
//   req_unsigned          zero-extend loads when 1
//   req_addr/req_wdata    byte address and store data (low bytes used)
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata/rsp_err     extended load data and error flag
// master: the core side.  slave: the memory side.
// -----------------------------------------------------------------------------
interface data_mem_lsu_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// -----------------------------------------------------------------------------
// data_mem_lsu
// Byte-addressable data memory with a load/store formatting stage. Requests are
// checked for size, range and alignment when accepted; stores write their bytes
// at the accept edge, loads read at the accept edge and the sign/zero-extended
// result is registered into a single-entry response slot.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    data_mem_lsu_if slave modport (request and response handshakes)
// Parameters:
//   XLEN             data width, 32 or 64
//   ABITS            byte-address bits of storage (depth = 2**ABITS bytes)
//   ALLOW_MISALIGNED 0: misaligned access is an error, 1: performed byte-wise
// -----------------------------------------------------------------------------
module data_mem_lsu #(
    parameter int XLEN             = 32,
    parameter int ABITS            = 12,
    parameter int ALLOW_MISALIGNED = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_lsu_if.slave  bus
);
    localparam int NLANES = XLEN / 8;
    localparam int DEPTH  = 2 ** ABITS;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_mem [DEPTH];
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_rsp_err;

    logic            w_rsp_valid;
    logic            w_req_ready;
    logic            w_accept;
    logic [3:0]      w_nbytes;
    logic [ABITS-1:0] w_base;
    logic [ABITS:0]  w_last;
    logic            w_err_size;
    logic            w_err_range;
    logic            w_err_align;
    logic            w_err;
    logic            w_mem_we;
    logic            w_sign;
    logic [XLEN-1:0] w_load_data;

    // ------------------------------------------------------------------------
    // Request decode and error checks
    // ------------------------------------------------------------------------
    assign w_nbytes = 4'd1 << bus.req_size;
    assign w_base   = bus.req_addr[ABITS-1:0];
    // One extra bit so an access running past the top of storage is visible
    // instead of wrapping around to address 0.
    assign w_last   = {1'b0, w_base} + (ABITS+1)'(w_nbytes) - (ABITS+1)'(1);

    assign w_err_size  = (XLEN == 32) && (bus.req_size == 2'd3);
    assign w_err_range = (|bus.req_addr[XLEN-1:ABITS]) ||
                         (w_last > (ABITS+1)'(DEPTH - 1));
    assign w_err_align = (ALLOW_MISALIGNED == 0) &&
                         ((w_base & ABITS'(w_nbytes - 4'd1)) != '0);
    assign w_err       = w_err_size || w_err_range || w_err_align;

    assign w_accept = bus.req_valid && w_req_ready;
    // The storage has no reset, so a request presented while reset is held
    // must be blocked here explicitly.
    assign w_mem_we = w_accept && bus.req_we && !w_err && rst_n;

    // ------------------------------------------------------------------------
    // Load path: gather N little-endian bytes, then fill the upper lanes
    // ------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        w_sign      = 1'b0;
        w_load_data = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (i == int'(w_nbytes) - 1) begin
                w_sign = r_mem[w_base + ABITS'(i)][7];
            end
        end
        // A full-width access has no fill lanes, so req_unsigned drops out.
        for (int i = 0; i < NLANES; i++) begin
            if (i < int'(w_nbytes)) begin
                w_load_data[8*i +: 8] = r_mem[w_base + ABITS'(i)];
            end else begin
                w_load_data[8*i +: 8] = {8{w_sign && !bus.req_unsigned}};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    // NOTE: the byte array is deliberately left out of reset; its contents are
    // undefined after power-up and resetting it would only cost a huge fan-out.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < NLANES; i++) begin
                if (i < int'(w_nbytes)) begin
                    r_mem[w_base + ABITS'(i)] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response register: reloads on every accept, held otherwise
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (bus.req_we || w_err) ? '0 : w_load_data;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rsp_valid  = (r_state == S_FULL);
        // A slot that is being drained this cycle can take the next request.
        w_req_ready  = !w_rsp_valid || bus.rsp_ready;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.rsp_ready && !w_accept) begin
                    w_state_next = S_EMPTY;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_data_mem_lsu
// Directed bench for data_mem_lsu. Two instances: XLEN=32 with alignment
// checking (ABITS=12) and XLEN=64 with misaligned access allowed (ABITS=8).
// Table-driven request/response vectors plus hand-written sequences for
// back-to-back hazards, backpressure and reset during a pending response.
// -----------------------------------------------------------------------------
module tb_data_mem_lsu;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    data_mem_lsu_if #(.XLEN(32)) b32 ();
    data_mem_lsu_if #(.XLEN(64)) b64 ();

    data_mem_lsu #(.XLEN(32), .ABITS(12), .ALLOW_MISALIGNED(0)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32.slave)
    );

    data_mem_lsu #(.XLEN(64), .ABITS(8), .ALLOW_MISALIGNED(1)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b64.slave)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t v32[$];
    vec_t v64[$];

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic drive(input bit wide, input vec_t v, input logic valid);
        if (wide) begin
            b64.req_we = v.we; b64.req_size = v.size; b64.req_unsigned = v.uns;
            b64.req_addr = v.addr; b64.req_wdata = v.wdata; b64.req_valid = valid;
        end else begin
            b32.req_we = v.we; b32.req_size = v.size; b32.req_unsigned = v.uns;
            b32.req_addr = v.addr[31:0]; b32.req_wdata = v.wdata[31:0]; b32.req_valid = valid;
        end
    endtask

    function automatic logic req_ready_of(input bit wide);
        return wide ? b64.req_ready : b32.req_ready;
    endfunction

    function automatic logic [63:0] rdata_of(input bit wide);
        return wide ? b64.rsp_rdata : {32'b0, b32.rsp_rdata};
    endfunction

    function automatic logic valid_of(input bit wide);
        return wide ? b64.rsp_valid : b32.rsp_valid;
    endfunction

    function automatic logic err_of(input bit wide);
        return wide ? b64.rsp_err : b32.rsp_err;
    endfunction

    // Present one request, wait (bounded) until it is accepted, and return
    // 1 time unit after the accepting edge with req_valid dropped.
    task automatic do_req(input bit wide, input vec_t v);
        int n = 0;
        @(negedge clk);
        drive(wide, v, 1'b1);
        while (!req_ready_of(wide) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 64'(n < 20), 64'd1);
        @(posedge clk);
        #1;
        if (wide) b64.req_valid = 1'b0;
        else      b32.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // ---------------- XLEN=32, aligned-only, 4 KiB ----------------
        v32.push_back(mk(1, 2, 0, 64'h10,       64'hDEADBEEF, 64'h0,        0));
        v32.push_back(mk(0, 0, 0, 64'h13,       64'h0,        64'hFFFFFFDE, 0));
        v32.push_back(mk(0, 1, 1, 64'h10,       64'h0,        64'h0000BEEF, 0));
        v32.push_back(mk(0, 1, 0, 64'h12,       64'h0,        64'hFFFFDEAD, 0));
        v32.push_back(mk(1, 0, 0, 64'h11,       64'hAAAAAA55, 64'h0,        0));
        v32.push_back(mk(0, 2, 0, 64'h10,       64'h0,        64'hDEAD55EF, 0));
        v32.push_back(mk(0, 2, 0, 64'h12,       64'h0,        64'h0,        1));
        v32.push_back(mk(1, 2, 0, 64'h12,       64'h12345678, 64'h0,        1));
        v32.push_back(mk(0, 2, 0, 64'h10,       64'h0,        64'hDEAD55EF, 0));
        v32.push_back(mk(0, 1, 0, 64'h11,       64'h0,        64'h0,        1));
        v32.push_back(mk(1, 2, 0, 64'h80000010, 64'h11111111, 64'h0,        1));
        v32.push_back(mk(0, 2, 0, 64'h10,       64'h0,        64'hDEAD55EF, 0));
        v32.push_back(mk(0, 2, 0, 64'hFFE,      64'h0,        64'h0,        1));
        v32.push_back(mk(0, 2, 0, 64'h1000,     64'h0,        64'h0,        1));
        v32.push_back(mk(0, 3, 0, 64'h10,       64'h0,        64'h0,        1));
        v32.push_back(mk(1, 0, 0, 64'hFFF,      64'h00000080, 64'h0,        0));
        v32.push_back(mk(0, 0, 0, 64'hFFF,      64'h0,        64'hFFFFFF80, 0));
        v32.push_back(mk(0, 0, 1, 64'hFFF,      64'h0,        64'h00000080, 0));
        v32.push_back(mk(1, 1, 0, 64'h20,       64'hFFFF8001, 64'h0,        0));
        v32.push_back(mk(0, 1, 0, 64'h20,       64'h0,        64'hFFFF8001, 0));
        v32.push_back(mk(0, 1, 1, 64'h20,       64'h0,        64'h00008001, 0));
        v32.push_back(mk(0, 0, 0, 64'h21,       64'h0,        64'hFFFFFF80, 0));
        v32.push_back(mk(0, 2, 1, 64'h10,       64'h0,        64'hDEAD55EF, 0));

        // ---------------- XLEN=64, misaligned allowed, 256 B ----------------
        v64.push_back(mk(1, 3, 0, 64'h03, 64'h0123456789ABCDEF, 64'h0,                0));
        v64.push_back(mk(0, 2, 0, 64'h05, 64'h0,                64'h00000000456789AB, 0));
        v64.push_back(mk(0, 2, 0, 64'h04, 64'h0,                64'h000000006789ABCD, 0));
        v64.push_back(mk(0, 1, 0, 64'h05, 64'h0,                64'hFFFFFFFFFFFF89AB, 0));
        v64.push_back(mk(0, 1, 1, 64'h06, 64'h0,                64'h0000000000006789, 0));
        v64.push_back(mk(0, 0, 0, 64'h06, 64'h0,                64'hFFFFFFFFFFFFFF89, 0));
        v64.push_back(mk(0, 3, 0, 64'h03, 64'h0,                64'h0123456789ABCDEF, 0));
        v64.push_back(mk(1, 2, 0, 64'h21, 64'hFFFFFFFF80000001, 64'h0,                0));
        v64.push_back(mk(0, 2, 0, 64'h21, 64'h0,                64'hFFFFFFFF80000001, 0));
        v64.push_back(mk(0, 2, 1, 64'h21, 64'h0,                64'h0000000080000001, 0));
        v64.push_back(mk(0, 2, 0, 64'hFE, 64'h0,                64'h0,                1));
        v64.push_back(mk(0, 0, 0, 64'h100,64'h0,                64'h0,                1));
        v64.push_back(mk(0, 3, 0, 64'hF9, 64'h0,                64'h0,                1));
        v64.push_back(mk(1, 3, 0, 64'hF8, 64'h1122334455667788, 64'h0,                0));
        v64.push_back(mk(0, 0, 1, 64'hFF, 64'h0,                64'h0000000000000011, 0));

        // ---------------- Reset ----------------
        rst_n = 1'b0;
        v = mk(0, 0, 0, 64'h0, 64'h0, 64'h0, 0);
        drive(1'b0, v, 1'b0);
        drive(1'b1, v, 1'b0);
        b32.rsp_ready = 1'b0;
        b64.rsp_ready = 1'b0;
        #22;
        check("rst_rsp_valid", 64'(b32.rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(b32.rsp_rdata), 64'd0);
        check("rst_rsp_err",   64'(b32.rsp_err),   64'd0);
        check("rst_req_ready", 64'(b32.req_ready), 64'd1);
        check("rst64_rsp_valid", 64'(b64.rsp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b32.rsp_ready = 1'b1;
        b64.rsp_ready = 1'b1;

        // ---------------- Table-driven vectors ----------------
        foreach (v32[i]) begin
            do_req(1'b0, v32[i]);
            check($sformatf("v32_%0d_valid", i), 64'(valid_of(1'b0)), 64'd1);
            check($sformatf("v32_%0d_rdata", i), rdata_of(1'b0), v32[i].exp_rdata);
            check($sformatf("v32_%0d_err", i),   64'(err_of(1'b0)), 64'(v32[i].exp_err));
        end
        foreach (v64[i]) begin
            do_req(1'b1, v64[i]);
            check($sformatf("v64_%0d_valid", i), 64'(valid_of(1'b1)), 64'd1);
            check($sformatf("v64_%0d_rdata", i), rdata_of(1'b1), v64[i].exp_rdata);
            check($sformatf("v64_%0d_err", i),   64'(err_of(1'b1)), 64'(v64[i].exp_err));
        end

        // ---------------- Store then load on the very next edge ----------------
        @(negedge clk);
        drive(1'b0, mk(1, 2, 0, 64'h40, 64'hCAFEF00D, 64'h0, 0), 1'b1);
        @(posedge clk); #1;
        check("b2b_store_valid", 64'(b32.rsp_valid), 64'd1);
        @(negedge clk);
        drive(1'b0, mk(0, 2, 0, 64'h40, 64'h0, 64'h0, 0), 1'b1);
        check("b2b_req_ready", 64'(b32.req_ready), 64'd1);
        @(posedge clk); #1;
        b32.req_valid = 1'b0;
        check("b2b_load_valid", 64'(b32.rsp_valid), 64'd1);
        check("b2b_load_rdata", 64'(b32.rsp_rdata), 64'hCAFEF00D);
        check("b2b_load_err",   64'(b32.rsp_err),   64'd0);
        @(posedge clk); #1;
        check("b2b_drained", 64'(b32.rsp_valid), 64'd0);

        // ---------------- Backpressure: hold the response 3 cycles ----------------
        @(negedge clk);
        b32.rsp_ready = 1'b0;
        drive(1'b0, mk(0, 2, 0, 64'h10, 64'h0, 64'h0, 0), 1'b1);
        @(posedge clk); #1;
        check("bp_first_valid", 64'(b32.rsp_valid), 64'd1);
        check("bp_first_rdata", 64'(b32.rsp_rdata), 64'hDEAD55EF);
        drive(1'b0, mk(0, 0, 1, 64'h13, 64'h0, 64'h0, 0), 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_req_ready", c), 64'(b32.req_ready), 64'd0);
            check($sformatf("bp_hold%0d_valid", c),     64'(b32.rsp_valid), 64'd1);
            check($sformatf("bp_hold%0d_rdata", c),     64'(b32.rsp_rdata), 64'hDEAD55EF);
            check($sformatf("bp_hold%0d_err", c),       64'(b32.rsp_err),   64'd0);
        end
        @(negedge clk);
        b32.rsp_ready = 1'b1;
        #1;
        check("bp_release_req_ready", 64'(b32.req_ready), 64'd1);
        @(posedge clk); #1;
        b32.req_valid = 1'b0;
        check("bp_second_valid", 64'(b32.rsp_valid), 64'd1);
        check("bp_second_rdata", 64'(b32.rsp_rdata), 64'h000000DE);
        @(posedge clk); #1;
        check("bp_drained", 64'(b32.rsp_valid), 64'd0);

        // ---------------- Reset while a store response is pending ----------------
        @(negedge clk);
        b32.rsp_ready = 1'b0;
        drive(1'b0, mk(1, 2, 0, 64'h50, 64'h0BADF00D, 64'h0, 0), 1'b1);
        @(posedge clk); #1;
        b32.req_valid = 1'b0;
        check("rstmid_pending", 64'(b32.rsp_valid), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid_dropped", 64'(b32.rsp_valid), 64'd0);
        check("rstmid_req_ready",     64'(b32.req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        b32.rsp_ready = 1'b1;
        do_req(1'b0, mk(0, 2, 0, 64'h50, 64'h0, 64'h0, 0));
        check("rstmid_store_kept", 64'(b32.rsp_rdata), 64'h0BADF00D);
        check("rstmid_load_err",   64'(b32.rsp_err),   64'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
